bcd_serial_adder: RTL and testbench
===================================

# bcd_serial_adder

Multi-digit BCD adder that adds two packed-BCD operands one decimal digit per clock, least-significant digit first, with a registered carry between digits. It sits directly upstream of the single-digit BCD adder datapath. It extends that stage to DIGITS-wide operands behind a start/done handshake, and its result feeds the display and readout logic. One shared digit-adjust sub-module performs the per-digit +6 correction.

## Interface
- DIGITS, 4, number of BCD digits per operand (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a  in  4*DIGITS  operand A, packed BCD, digit 0 in [3:0]
- b  in  4*DIGITS  operand B, packed BCD
- cin  in  1  carry into digit 0
- busy  out  1  high while digits are being processed (ADD state)
- done  out  1  one-cycle pulse: sum/cout/err valid
- sum  out  4*DIGITS  registered BCD result, held until next completion
- cout  out  1  carry out of the most-significant digit
- err  out  1  some operand digit was >9 in the completed operation

## Operation
- FSM states: IDLE, ADD, DONE.
- IDLE: on start=1, latch a, b, cin into working registers. Set digit index idx=0, set the carry register to cin, clear the err accumulator, and go to ADD. start=0 keeps the FSM in IDLE.
- ADD: process digit idx each cycle.
  - t = a[idx] + b[idx] + carry, 5-bit unsigned.
  - If t > 9: digit = (t + 6)[3:0] and carry = 1. Otherwise digit = t[3:0] and carry = 0.
  - If a[idx] > 9 or b[idx] > 9, set the err accumulator.
  - After idx = DIGITS-1: load sum, cout and err from the working values, and go to DONE.
- DONE: done = 1 for exactly one cycle, then return to IDLE unconditionally.
- start is ignored in ADD and DONE. Operand changes after acceptance have no effect on the current operation.
- Invalid digits are not rejected. They are computed with the same rule; for example, digit values 15 + 15 + 1 = 31 give digit 5 with carry 1.
- sum, cout and err change only on entry to DONE. They hold the previous result throughout ADD.

## Timing
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, sum=0, cout=0, err=0; idx, carry and working registers are cleared. An in-flight operation is aborted with no done pulse.
- Edge E0 accepts start. busy is high from E0 until E_DIGITS.
- Edges E1..E_DIGITS process digits 0..DIGITS-1. At E_DIGITS, busy falls, done rises, and the outputs update.
- At E_DIGITS+1, done falls and the FSM is back in IDLE. The earliest next accept is E_DIGITS+2.
- Latency from accept to done is DIGITS cycles. Throughput is one operation per DIGITS+2 cycles when start is held high.
- busy and done are never high together.

## Structure
- Shared package bcd_pkg:
  - BCD_W = 4, BCD_MAX = 9, BCD_ADJ = 6
  - FSM state encoding (IDLE, ADD, DONE)
- Sub-module bcd_digit_add: combinational. Inputs are two 4-bit digits and a carry. Outputs are the corrected digit, the carry out, and an invalid flag.
- Top module: FSM, idx counter (width clog2(DIGITS), minimum 1 bit), carry register, working shift registers for a/b/sum, and output registers.

## Test plan
All scenarios use DIGITS=4.
- Reset with no stimulus: busy, done, sum, cout and err are 0. Asynchronous reset mid-clock clears the outputs immediately.
- a=0x1234, b=0x5678, cin=0, start at E0: busy high E0–E4, done high only after E4, sum=0x6912, cout=0, err=0.
- a=0x9999, b=0x0001, cin=0 gives sum=0x0000, cout=1. Then a=0x0999, b=0x0001, cin=1 gives sum=0x1001, cout=0.
- a=0x00A0, b=0x0000, cin=0: err=1, sum=0x0100, cout=0. The next valid operation clears err.
- start pulsed again during ADD and change a mid-operation: no effect, result matches the operands latched at E0. rst pulsed during ADD: no done, outputs 0, and a following start completes normally.
- start held high continuously: done pulses every 6 cycles, and each result matches the operands present at its accept edge.

Source files
------------

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants and FSM encoding for the serial BCD adder
package bcd_pkg;

   localparam int              BCD_W   = 4;
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
   localparam logic [BCD_W-1:0] BCD_ADJ = 4'd6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADD  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// rtl/bcd_digit_add.sv - combinational single-digit BCD add with +6 correction
module bcd_digit_add
   import bcd_pkg::*;
(
   input  logic [BCD_W-1:0] a_i,
   input  logic [BCD_W-1:0] b_i,
   input  logic             c_i,
   output logic [BCD_W-1:0] digit_o,
   output logic             carry_o,
   output logic             inv_o
);

   logic [BCD_W:0] t;
   logic [BCD_W:0] t_adj;

   assign t     = {1'b0, a_i} + {1'b0, b_i} + {{BCD_W{1'b0}}, c_i};
   assign t_adj = t + {1'b0, BCD_ADJ};

   // Out-of-range digits go through the same rule; only the flag marks them.
   always_comb begin
      digit_o = t[BCD_W-1:0];
      carry_o = 1'b0;
      if (t > {1'b0, BCD_MAX}) begin
         digit_o = t_adj[BCD_W-1:0];
         carry_o = 1'b1;
      end
   end

   assign inv_o = (a_i > BCD_MAX) || (b_i > BCD_MAX);

endmodule

// File: rtl/bcd_serial_adder.sv
// rtl/bcd_serial_adder.sv - multi-digit BCD adder, one digit per clock, LSD first
module bcd_serial_adder
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   input  logic                  cin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   sum,
   output logic                  cout,
   output logic                  err
);

   localparam int W     = BCD_W * DIGITS;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             carry_q, carry_d;
   logic             err_acc_q, err_acc_d;
   logic [W-1:0]     a_w_q, a_w_d;
   logic [W-1:0]     b_w_q, b_w_d;
   logic [W-1:0]     s_w_q, s_w_d;
   logic [W-1:0]     sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             err_q, err_d;

   logic [BCD_W-1:0] dig;
   logic             dig_c;
   logic             dig_inv;
   logic [W+BCD_W-1:0] s_cat;

   bcd_digit_add u_digit (
      .a_i     (a_w_q[BCD_W-1:0]),
      .b_i     (b_w_q[BCD_W-1:0]),
      .c_i     (carry_q),
      .digit_o (dig),
      .carry_o (dig_c),
      .inv_o   (dig_inv)
   );

   // New digits enter at the top so digit 0 lands in [3:0] after the last shift.
   assign s_cat = {dig, s_w_q};

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      carry_d   = carry_q;
      err_acc_d = err_acc_q;
      a_w_d     = a_w_q;
      b_w_d     = b_w_q;
      s_w_d     = s_w_q;
      sum_d     = sum_q;
      cout_d    = cout_q;
      err_d     = err_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_w_d     = a;
               b_w_d     = b;
               carry_d   = cin;
               idx_d     = '0;
               err_acc_d = 1'b0;
               s_w_d     = '0;
               state_d   = ST_ADD;
            end
         end
         ST_ADD: begin
            a_w_d     = a_w_q >> BCD_W;
            b_w_d     = b_w_q >> BCD_W;
            s_w_d     = s_cat[W+BCD_W-1:BCD_W];
            carry_d   = dig_c;
            err_acc_d = err_acc_q | dig_inv;
            idx_d     = idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) begin
               sum_d   = s_cat[W+BCD_W-1:BCD_W];
               cout_d  = dig_c;
               err_d   = err_acc_q | dig_inv;
               idx_d   = '0;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         carry_q   <= 1'b0;
         err_acc_q <= 1'b0;
         a_w_q     <= '0;
         b_w_q     <= '0;
         s_w_q     <= '0;
         sum_q     <= '0;
         cout_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         carry_q   <= carry_d;
         err_acc_q <= err_acc_d;
         a_w_q     <= a_w_d;
         b_w_q     <= b_w_d;
         s_w_q     <= s_w_d;
         sum_q     <= sum_d;
         cout_q    <= cout_d;
         err_q     <= err_d;
      end
   end

   assign busy = (state_q == ST_ADD);
   assign done = (state_q == ST_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb/tb_bcd_serial_adder.sv - directed self-checking bench for bcd_serial_adder
module tb_bcd_serial_adder;

   localparam int DIGITS = 4;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        busy;
   logic        done;
   logic [15:0] sum;
   logic        cout;
   logic        err;

   int n_checks;
   int n_fails;

   bcd_serial_adder #(.DIGITS(DIGITS)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input string tag, output int n);
      n = 0;
      while (n < 20) begin
         @(negedge clk);
         n++;
         if (done === 1'b1) break;
      end
      if (done !== 1'b1) check({tag, "_timeout"}, {31'd0, done}, 32'd1);
   endtask

   task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic cv, input logic [15:0] exp_sum, input logic exp_cout,
                         input logic exp_err);
      int n;
      a     = av;
      b     = bv;
      cin   = cv;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(tag, n);
      check({tag, "_lat"},  n, DIGITS);
      check({tag, "_sum"},  {16'd0, sum}, {16'd0, exp_sum});
      check({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_cout});
      check({tag, "_err"},  {31'd0, err}, {31'd0, exp_err});
      @(negedge clk);
      check({tag, "_done_fall"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      int n;
      logic saw_done;
      n_checks = 0;
      n_fails  = 0;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_sum",  {16'd0, sum},  32'd0);
      check("rst_cout", {31'd0, cout}, 32'd0);
      check("rst_err",  {31'd0, err},  32'd0);

      // basic add with per-cycle busy/done tracking
      a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("e0_busy", {31'd0, busy}, 32'd1);
      check("e0_done", {31'd0, done}, 32'd0);
      for (int i = 1; i < DIGITS; i++) begin
         @(negedge clk);
         check("add_busy", {31'd0, busy}, 32'd1);
         check("add_done", {31'd0, done}, 32'd0);
         check("add_sum_hold", {16'd0, sum}, 32'd0);
      end
      @(negedge clk);
      check("e4_busy", {31'd0, busy}, 32'd0);
      check("e4_done", {31'd0, done}, 32'd1);
      check("e4_sum",  {16'd0, sum},  32'h6912);
      check("e4_cout", {31'd0, cout}, 32'd0);
      check("e4_err",  {31'd0, err},  32'd0);
      @(negedge clk);
      check("e5_done", {31'd0, done}, 32'd0);
      check("e5_busy", {31'd0, busy}, 32'd0);
      check("e5_sum",  {16'd0, sum},  32'h6912);

      run_op("carry_all", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("cin_ripple", 16'h0999, 16'h0001, 1'b1, 16'h1001, 1'b0, 1'b0);
      run_op("bad_digit", 16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1);
      run_op("err_clear", 16'h0015, 16'h0027, 1'b0, 16'h0042, 1'b0, 1'b0);
      run_op("ff_plus_1", 16'h000F, 16'h000F, 1'b1, 16'h0015, 1'b0, 1'b1);

      // start re-pulsed and operands changed while ADD is running
      a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; a = 16'h9999; b = 16'h9999; cin = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("interfere", n);
      check("interfere_lat",  n, 2);
      check("interfere_sum",  {16'd0, sum},  32'h3333);
      check("interfere_cout", {31'd0, cout}, 32'd0);
      @(negedge clk);
      check("interfere_idle", {30'd0, busy, done}, 32'd0);

      // asynchronous reset in the middle of ADD
      a = 16'h8888; b = 16'h8888; cin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_done", {31'd0, done}, 32'd0);
      check("arst_sum",  {16'd0, sum},  32'd0);
      check("arst_cout", {31'd0, cout}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      saw_done = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (done === 1'b1) saw_done = 1'b1;
      end
      check("arst_no_done", {31'd0, saw_done}, 32'd0);
      run_op("post_rst", 16'h4321, 16'h1234, 1'b0, 16'h5555, 1'b0, 1'b0);

      // start held high: one operation every DIGITS+2 cycles
      a = 16'h0102; b = 16'h0304; cin = 1'b0; start = 1'b1;
      wait_done("held1", n);
      check("held1_lat", n, DIGITS + 1);
      check("held1_sum", {16'd0, sum}, 32'h0406);
      a = 16'h0500; b = 16'h0500;
      wait_done("held2", n);
      check("held2_period", n, DIGITS + 2);
      check("held2_sum", {16'd0, sum}, 32'h1000);
      a = 16'h9000; b = 16'h1000;
      wait_done("held3", n);
      check("held3_period", n, DIGITS + 2);
      check("held3_sum",  {16'd0, sum},  32'h0000);
      check("held3_cout", {31'd0, cout}, 32'd1);
      start = 1'b0;
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
